memory_writeback: RTL
=====================

// Module: memory_writeback
// PURPOSE
//  Final pipeline stage behind execute. Accepts committed instructions over the submit/ready
//  handshake, performs optional load/store on the data memory bus, and drives register-file
//  write-back (o_reg_ie/o_reg_data) back into execute. Raises o_mem_exception on bus faults.
// PARAMETERS
//  TIMEOUT     255  bus watchdog in cycles waiting for ack; 0 = watchdog disabled
//  TIMEOUT_W   8    width of watchdog counter (must hold TIMEOUT)
// PORTS
//  i_clk            in   1        clock
//  i_rst            in   1        synchronous reset, active high
//  i_submit         in   1        instruction valid from execute
//  o_ready          out  1        stage can accept (execute i_next_ready)
//  i_data           in   `RW      ALU result / store data / sreg value
//  i_addr           in   `RW      memory byte address
//  i_reg_ie         in   `REGNO   one-hot destination register enable
//  i_mem_access     in   1        instruction accesses memory
//  i_mem_we         in   1        1 = store, 0 = load
//  i_mem_width      in   1        1 = 8-bit, 0 = 16-bit
//  i_c_data_page    in   1        data paging enable, forwarded with request
//  o_reg_ie         out  `REGNO   register-file write enable
//  o_reg_data       out  `RW      register-file write data
//  o_mem_req        out  1        bus request, held until ack/err/timeout
//  o_mem_we         out  1        bus write
//  o_mem_addr       out  `RW      word address = captured addr >> 1
//  o_mem_data       out  `RW      store data, lane steered
//  o_mem_sel        out  2        byte lane select {hi,lo}
//  o_mem_paging     out  1        captured i_c_data_page
//  i_mem_data       in   `RW      load data
//  i_mem_ack        in   1        bus transfer complete
//  i_mem_err        in   1        bus fault
//  o_mem_exception  out  1        one-cycle fault pulse to execute
// BEHAVIOUR
//  Reset: state IDLE; o_mem_req, o_mem_we, o_mem_sel, o_mem_exception, o_mem_paging = 0;
//   o_reg_ie = 0; captured regs cleared; o_ready = 1 (combinational, state==IDLE).
//  States: IDLE, WAIT.
//  IDLE, i_submit & ~i_mem_access: same-cycle combinational write-back, o_reg_ie=i_reg_ie,
//   o_reg_data=i_data; stay IDLE. Zero-latency; execute RAW logic relies on this.
//  IDLE, i_submit & i_mem_access: capture addr/data/reg_ie/we/width/page; next cycle
//   o_mem_req=1, state WAIT, watchdog cleared. No write-back in submit cycle.
//  WAIT: o_ready=0; requests held stable. Per cycle, priority err > ack > timeout:
//   - i_mem_err: o_mem_exception=1 next cycle, no write-back, req drop, -> IDLE.
//   - i_mem_ack & load: combinational write-back in ack cycle, o_reg_ie=captured reg_ie,
//     o_reg_data=aligned i_mem_data; req drop next edge, -> IDLE.
//   - i_mem_ack & store: no write-back, -> IDLE.
//   - watchdog reaches TIMEOUT (TIMEOUT!=0): treated as i_mem_err.
//  o_reg_ie = 0 in every other cycle; i_submit ignored while WAIT (o_ready low).
//  Lanes: 16-bit: sel=2'b11, data as-is. 8-bit: sel = addr[0] ? 2'b10 : 2'b01; store
//   byte replicated on both lanes; load takes addressed lane, zero-extended to `RW.
//  Reset mid-WAIT: request dropped same edge, no write-back, no exception.
// CONFIGURATION
//  MEM_UNALIGNED_TRAP_EN defined: 16-bit access with i_addr[0]=1 issues no bus cycle,
//   no write-back; o_mem_exception pulses next cycle; stays IDLE.
//  Not defined: i_addr[0] ignored for 16-bit accesses (aligned down), access proceeds.
// STRUCTURE
//  `RW, `REGNO and width encodings come from config.v; state encoding local parameters.
//  Sub-module mem_lane_align: combinational store steering/sel and load extraction.
// TESTING
//  ALU op, i_data=16'h1234, i_reg_ie=bit3 -> same cycle o_reg_ie=bit3, o_reg_data=16'h1234.
//  16-bit load addr 16'h0010, ack after 3 cycles with 16'hBEEF -> o_mem_addr=16'h0008,
//   sel=11, o_ready low 4 cycles, write-back 16'hBEEF in ack cycle.
//  8-bit store addr 16'h0003 data 16'h00A5 -> sel=10, o_mem_data=16'hA5A5, no write-back.
//  8-bit load addr 16'h0002, i_mem_data=16'hCC77 -> o_reg_data=16'h0077.
//  load with i_mem_err in 2nd WAIT cycle -> one o_mem_exception pulse, o_reg_ie stays 0;
//   no ack for 255 cycles -> same response.
//  16-bit load addr 16'h0005: with MEM_UNALIGNED_TRAP_EN -> exception, o_mem_req never 1;
//   without -> o_mem_addr=16'h0002, normal load.

Source files
------------

// File: rtl/memory_writeback_pkg.sv
// Shared types and widths for the memory/write-back stage.
// Register width, one-hot register count, access-width codes and FSM states.
package memory_writeback_pkg;

    localparam int RW    = 16;
    localparam int REGNO = 8;

    localparam logic WIDTH_8  = 1'b1;
    localparam logic WIDTH_16 = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/memory_writeback_lane_align.sv
// Byte-lane steering for the data bus: store replication, lane select
// and load extraction with zero extension.
module mem_lane_align
    import memory_writeback_pkg::*;
(
    input  logic          width,
    input  logic          addr_lsb,
    input  logic [RW-1:0] store_in,
    input  logic [RW-1:0] load_in,
    output logic [1:0]    sel,
    output logic [RW-1:0] store_out,
    output logic [RW-1:0] load_out
);

    always_comb begin
        sel       = 2'b11;
        store_out = store_in;
        load_out  = load_in;
        if (width == WIDTH_8) begin
            sel       = addr_lsb ? 2'b10 : 2'b01;
            store_out = {2{store_in[7:0]}};
            load_out  = {{(RW-8){1'b0}},
                         (addr_lsb ? load_in[15:8] : load_in[7:0])};
        end
    end

endmodule

// File: rtl/memory_writeback.sv
// Memory/write-back stage: ALU write-back, data bus load/store, fault pulse.
// Optional MEM_UNALIGNED_TRAP_EN traps odd-address 16-bit accesses.
module memory_writeback
    import memory_writeback_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [RW-1:0]    i_data,
    input  logic [RW-1:0]    i_addr,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_mem_width,
    input  logic             i_c_data_page,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    output logic [1:0]       o_mem_sel,
    output logic             o_mem_paging,
    input  logic [RW-1:0]    i_mem_data,
    input  logic             i_mem_ack,
    input  logic             i_mem_err,
    output logic             o_mem_exception
);

    state_t state, state_nx;

    logic [RW-1:0]        addr_q, data_q;
    logic [REGNO-1:0]     reg_ie_q;
    logic                 we_q, width_q, page_q;
    logic                 req_q, exc_q;
    logic [TIMEOUT_W-1:0] wdog;

    logic          timeout, trap, start, fault;
    logic [1:0]    sel_al;
    logic [RW-1:0] st_al, ld_al;

    mem_lane_align u_align (
        .width     (width_q),
        .addr_lsb  (addr_q[0]),
        .store_in  (data_q),
        .load_in   (i_mem_data),
        .sel       (sel_al),
        .store_out (st_al),
        .load_out  (ld_al)
    );

`ifdef MEM_UNALIGNED_TRAP_EN
    assign trap = i_mem_access & (i_mem_width == WIDTH_16) & i_addr[0];
`else
    assign trap = 1'b0;
`endif

    assign timeout = (TIMEOUT != 0) && (wdog == TIMEOUT_W'(TIMEOUT));

    always_comb begin
        state_nx   = state;
        o_reg_ie   = '0;
        o_reg_data = '0;
        start      = 1'b0;
        fault      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_submit) begin
                    if (!i_mem_access) begin
                        o_reg_ie   = i_reg_ie;
                        o_reg_data = i_data;
                    end else if (trap) begin
                        fault = 1'b1;
                    end else begin
                        start    = 1'b1;
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (i_mem_err) begin
                    fault    = 1'b1;
                    state_nx = ST_IDLE;
                end else if (i_mem_ack) begin
                    if (!we_q) begin
                        o_reg_ie   = reg_ie_q;
                        o_reg_data = ld_al;
                    end
                    state_nx = ST_IDLE;
                end else if (timeout) begin
                    fault    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            reg_ie_q <= '0;
            we_q     <= 1'b0;
            width_q  <= 1'b0;
            page_q   <= 1'b0;
            req_q    <= 1'b0;
            exc_q    <= 1'b0;
            wdog     <= '0;
        end else begin
            exc_q <= fault;
            if (start) begin
                addr_q   <= i_addr;
                data_q   <= i_data;
                reg_ie_q <= i_reg_ie;
                we_q     <= i_mem_we;
                width_q  <= i_mem_width;
                page_q   <= i_c_data_page;
                req_q    <= 1'b1;
                wdog     <= '0;
            end else if (state == ST_WAIT) begin
                if (state_nx == ST_IDLE) req_q <= 1'b0;
                else                     wdog  <= wdog + 1'b1;
            end
        end
    end

    // Bus qualifiers are gated so an idle bus shows no write/lane activity.
    assign o_ready         = (state == ST_IDLE);
    assign o_mem_req       = req_q;
    assign o_mem_we        = req_q & we_q;
    assign o_mem_sel       = req_q ? sel_al : 2'b00;
    assign o_mem_addr      = {1'b0, addr_q[RW-1:1]};
    assign o_mem_data      = st_al;
    assign o_mem_paging    = page_q;
    assign o_mem_exception = exc_q;

endmodule
